// File: rtl/fir_mc_serial_pkg.sv
// Shared widths, FSM encoding and output rounding/saturation for the serial multi-channel FIR.
// The accumulator is sized so that MAX_TAPS full-scale products can never wrap.
package fir_mc_serial_pkg;

    localparam int NUM_CH   = 2;
    localparam int IN_W     = 3;
    localparam int COEF_W   = 16;
    localparam int MAX_TAPS = 32;
    localparam int OUT_W    = 16;
    localparam int SHIFT    = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int AW     = clog2(MAX_TAPS);
    localparam int NW     = AW + 1;
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int PROD_W = IN_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_MAC, ST_OUT} state_t;

    // Half an output LSB; evaluates to zero when no shift is applied.
    localparam logic signed [ACC_W:0] ROUND_K = (ACC_W + 1)'((2 ** SHIFT) / 2);
    localparam logic signed [ACC_W:0] SAT_HI  = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO  = -SAT_HI - (ACC_W + 1)'(1);

    function automatic logic signed [OUT_W-1:0] roundSat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] r;
        r = ((ACC_W + 1)'(acc) + ROUND_K) >>> SHIFT;
        if (r > SAT_HI) return SAT_HI[OUT_W-1:0];
        if (r < SAT_LO) return SAT_LO[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fir_mc_serial_if.sv
// Control, coefficient-write, sample and result signals of the serial FIR.
// master drives the strobe/coefficient/sample side; slave is the filter.
interface fir_mc_serial_if;
    import fir_mc_serial_pkg::*;

    logic                     iEnSample;
    logic                     iCoeffUpdateFlag;
    logic                     iCoeffWrEn;
    logic [AW-1:0]            iAddrRam;
    logic signed [COEF_W-1:0] iWrDtRam;
    logic [NW-1:0]            iNumOfCoeff;
    logic [NUM_CH*IN_W-1:0]   iFirIn;
    logic signed [OUT_W-1:0]  oFirOut;
    logic [CH_W-1:0]          oChannel;
    logic                     oValid;
    logic                     oBusy;
    logic                     oOverrun;

    modport master (
        output iEnSample, iCoeffUpdateFlag, iCoeffWrEn, iAddrRam, iWrDtRam, iNumOfCoeff, iFirIn,
        input  oFirOut, oChannel, oValid, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample, iCoeffUpdateFlag, iCoeffWrEn, iAddrRam, iWrDtRam, iNumOfCoeff, iFirIn,
        output oFirOut, oChannel, oValid, oBusy, oOverrun
    );

endinterface

// File: rtl/fir_mc_serial_coeff_ram.sv
// Coefficient store: one synchronous write port, one combinational read port.
// Read data follows rdAddr in the same cycle; no reset, contents survive iRst.
module fir_mc_serial_coeff_ram import fir_mc_serial_pkg::*; (
    input  logic                     iClk12M,
    input  logic                     wrEn,
    input  logic [AW-1:0]            wrAddr,
    input  logic signed [COEF_W-1:0] wrDat,
    input  logic [AW-1:0]            rdAddr,
    output logic signed [COEF_W-1:0] rdDat
);

    logic signed [COEF_W-1:0] mem [MAX_TAPS];

    always_ff @(posedge iClk12M) begin
        if (wrEn) mem[wrAddr] <= wrDat;
    end

    assign rdDat = mem[rdAddr];

endmodule

// File: rtl/fir_mc_serial.sv
// Time-multiplexed FIR: one MAC walks N taps for each channel in turn after every sample strobe.
// Channel c result appears (c+1)(N+1)+1 cycles after the strobe; strobes while busy are dropped and flagged.
module fir_mc_serial import fir_mc_serial_pkg::*; (
    input  logic           iClk12M,
    input  logic           iRst,
    fir_mc_serial_if.slave bus
);

    state_t                   state;
    logic [AW-1:0]            wp, headPtr, rdPtr, tap;
    logic [NW-1:0]            nTaps, nClamp;
    logic [CH_W-1:0]          ch;
    logic [NUM_CH*IN_W-1:0]   sampLatch;
    logic signed [IN_W-1:0]   dly [NUM_CH][MAX_TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [COEF_W-1:0] coefRd;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  firOut;
    logic [CH_W-1:0]          chan;
    logic                     valid, busy, overrun;
    logic                     lastTap, lastCh, coefWe;

    assign coefWe  = bus.iCoeffWrEn && bus.iCoeffUpdateFlag && (state == ST_IDLE);
    assign lastTap = ({1'b0, tap} == nTaps - NW'(1));
    assign lastCh  = (ch == CH_W'(NUM_CH - 1));
    assign prod    = PROD_W'(dly[ch][rdPtr]) * PROD_W'(coefRd);

    always_comb begin
        nClamp = bus.iNumOfCoeff;
        if (bus.iNumOfCoeff == '0)                nClamp = NW'(1);
        else if (bus.iNumOfCoeff > NW'(MAX_TAPS)) nClamp = NW'(MAX_TAPS);
    end

    fir_mc_serial_coeff_ram uCoeffRam (
        .iClk12M (iClk12M),
        .wrEn    (coefWe),
        .wrAddr  (bus.iAddrRam),
        .wrDat   (bus.iWrDtRam),
        .rdAddr  (tap),
        .rdDat   (coefRd)
    );

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int t = 0; t < MAX_TAPS; t++)
                    dly[c][t] <= '0;
        end else if (state == ST_LOAD) begin
            for (int c = 0; c < NUM_CH; c++)
                dly[c][wp] <= sampLatch[c*IN_W +: IN_W];
        end
    end

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            wp        <= '0;
            headPtr   <= '0;
            rdPtr     <= '0;
            tap       <= '0;
            nTaps     <= NW'(1);
            ch        <= '0;
            acc       <= '0;
            sampLatch <= '0;
            firOut    <= '0;
            chan      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= bus.iEnSample && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (bus.iEnSample && !bus.iCoeffUpdateFlag) begin
                        sampLatch <= bus.iFirIn;
                        nTaps     <= nClamp;
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    headPtr <= wp;
                    rdPtr   <= wp;
                    wp      <= (wp == AW'(MAX_TAPS - 1)) ? '0 : wp + 1'b1;
                    tap     <= '0;
                    ch      <= '0;
                    acc     <= '0;
                    state   <= ST_MAC;
                end
                ST_MAC: begin
                    // Walk backwards through the circular delay line: tap k sees sample n-k.
                    acc   <= acc + ACC_W'(prod);
                    rdPtr <= (rdPtr == '0) ? AW'(MAX_TAPS - 1) : rdPtr - 1'b1;
                    tap   <= tap + 1'b1;
                    if (lastTap) state <= ST_OUT;
                end
                ST_OUT: begin
                    firOut <= roundSat(acc);
                    chan   <= ch;
                    valid  <= 1'b1;
                    acc    <= '0;
                    tap    <= '0;
                    rdPtr  <= headPtr;
                    if (lastCh) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ST_MAC;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oFirOut  = firOut;
    assign bus.oChannel = chan;
    assign bus.oValid   = valid;
    assign bus.oBusy    = busy;
    assign bus.oOverrun = overrun;

endmodule

// File: tb/tb_fir_mc_serial.sv
// Self-checking bench for fir_mc_serial against a tap-history / coefficient-array reference model.
module tb_fir_mc_serial;

    localparam int TAPS   = 32;
    localparam int SH     = 0;
    localparam int NONE   = -10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mc_serial_if bus();

    fir_mc_serial dut (
        .iClk12M (clk),
        .iRst    (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int coefM [TAPS];
    int histM [2][TAPS];
    int listC [21] = '{13, 0, -19, 24, 0, -37, 48, 0, -102, 206, 500, 206, -102, 0, 48, -37, 0, 24, -19, 0, 13};

    function automatic void clearHist();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TAPS; k++)
                histM[c][k] = 0;
    endfunction

    function automatic void pushHist(input int a, input int b);
        for (int k = TAPS - 1; k > 0; k--) begin
            histM[0][k] = histM[0][k-1];
            histM[1][k] = histM[1][k-1];
        end
        histM[0][0] = a;
        histM[1][0] = b;
    endfunction

    function automatic int modelOut(input int c, input int n);
        longint acc;
        acc = 0;
        for (int k = 0; k < n; k++) acc += longint'(coefM[k]) * longint'(histM[c][k]);
        acc = (acc + longint'((1 << SH) >> 1)) >>> SH;
        if (acc > 32767)  return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic writeCoef(input int addr, input int val);
        @(negedge clk);
        bus.iCoeffUpdateFlag = 1'b1;
        bus.iCoeffWrEn       = 1'b1;
        bus.iAddrRam         = 5'(addr);
        bus.iWrDtRam         = 16'(val);
        @(negedge clk);
        bus.iCoeffWrEn       = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        coefM[addr] = val;
    endtask

    task automatic loadList();
        for (int a = 0; a < TAPS; a++) writeCoef(a, (a < 21) ? listC[a] : 0);
    endtask

    // One accepted strobe; optional overrun strobe at cycle ovAt and illegal coefficient write at cycle wrAt.
    task automatic strobe(input int a, input int b, input int n, input int ovAt, input int wrAt);
        int nEff, got, lat;
        int expv [2];
        logic signed [15:0] e16;
        nEff = (n == 0) ? 1 : (n > TAPS) ? TAPS : n;
        pushHist(a, b);
        expv[0] = modelOut(0, nEff);
        expv[1] = modelOut(1, nEff);
        @(negedge clk);
        bus.iFirIn      = {3'(b), 3'(a)};
        bus.iNumOfCoeff = 6'(n);
        bus.iEnSample   = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 2; cyc++) begin
            @(negedge clk);
            bus.iEnSample = 1'b0;
            if (cyc == 0) begin
                checks++;
                if (bus.oBusy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_strobe: oBusy=%b expected 1", bus.oBusy);
                end
            end
            if (cyc == ovAt) begin
                checks++;
                if (bus.oOverrun !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_pulse: oOverrun=%b expected 1", bus.oOverrun);
                end
            end
            if (cyc == ovAt + 1) begin
                checks++;
                if (bus.oOverrun !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun_one_cycle: oOverrun=%b expected 0", bus.oOverrun);
                end
            end
            if (bus.oValid === 1'b1) begin
                lat = (got + 1) * (nEff + 1) + 1;
                e16 = 16'(expv[got]);
                checks++;
                if (bus.oFirOut !== e16) begin
                    errors++;
                    $display("FAIL out_value ch%0d n=%0d: got %0d expected %0d", got, n, bus.oFirOut, e16);
                end
                checks++;
                if (bus.oChannel !== 1'(got)) begin
                    errors++;
                    $display("FAIL out_channel: got %0d expected %0d", bus.oChannel, got);
                end
                checks++;
                if (cyc != lat) begin
                    errors++;
                    $display("FAIL latency ch%0d n=%0d: got %0d expected %0d", got, n, cyc, lat);
                end
                if (got == 1) begin
                    checks++;
                    if (bus.oBusy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_drop: oBusy=%b expected 0", bus.oBusy);
                    end
                end
                got++;
            end
            if (cyc == ovAt - 1) begin
                bus.iEnSample = 1'b1;
                bus.iFirIn    = 6'($urandom);
            end
            if (cyc == wrAt) begin
                bus.iCoeffUpdateFlag = 1'b1;
                bus.iCoeffWrEn       = 1'b1;
                bus.iAddrRam         = 5'd0;
                bus.iWrDtRam         = 16'($urandom_range(1000, 30000));
            end
            if (cyc == wrAt + 1) begin
                bus.iCoeffUpdateFlag = 1'b0;
                bus.iCoeffWrEn       = 1'b0;
            end
        end
        if (got < 2) begin
            errors++;
            $display("FAIL valid_timeout: got %0d results expected 2", got);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0 || bus.oOverrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: v/b/o=%b%b%b expected 000", bus.oValid, bus.oBusy, bus.oOverrun);
        end
        checks++;
        if (bus.oFirOut !== 16'sd0 || bus.oChannel !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: out=%0d ch=%0d expected 0/0", bus.oFirOut, bus.oChannel);
        end
        rst = 1'b0;
        clearHist();
    endtask

    task automatic test_impulse(input int a, input int b);
        strobe(a, b, 21, NONE, NONE);
        for (int j = 0; j < 22; j++) strobe(0, 0, 21, NONE, NONE);
    endtask

    task automatic test_saturation();
        writeCoef(0, 32767);
        strobe(3, -4, 1, NONE, NONE);
        writeCoef(0, listC[0]);
    endtask

    task automatic test_overrun();
        strobe(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, 21, 10, NONE);
        strobe(3, -3, 21, NONE, NONE);
        strobe(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, 21, NONE, NONE);
    endtask

    task automatic test_flag_strobe();
        int busyCnt, validCnt;
        busyCnt = 0;
        validCnt = 0;
        @(negedge clk);
        bus.iCoeffUpdateFlag = 1'b1;
        bus.iFirIn           = 6'b001_011;
        bus.iEnSample        = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            bus.iEnSample = 1'b0;
            if (bus.oBusy === 1'b1 || bus.oOverrun === 1'b1) busyCnt++;
            if (bus.oValid === 1'b1) validCnt++;
        end
        bus.iCoeffUpdateFlag = 1'b0;
        checks++;
        if (busyCnt != 0 || validCnt != 0) begin
            errors++;
            $display("FAIL flag_strobe_ignored: busy/overrun cycles %0d valid cycles %0d expected 0/0", busyCnt, validCnt);
        end
    endtask

    task automatic test_write_while_busy();
        strobe(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, 21, NONE, 5);
        strobe(3, -2, 21, NONE, NONE);
    endtask

    task automatic test_reset_mid_mac();
        @(negedge clk);
        bus.iFirIn      = 6'b101_011;
        bus.iNumOfCoeff = 6'd21;
        bus.iEnSample   = 1'b1;
        @(negedge clk);
        bus.iEnSample = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.oBusy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: oBusy=%b expected 1", bus.oBusy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0 || bus.oOverrun !== 1'b0 || bus.oFirOut !== 16'sd0) begin
            errors++;
            $display("FAIL reset_mid_mac: v/b/o=%b%b%b out=%0d expected 000/0", bus.oValid, bus.oBusy, bus.oOverrun, bus.oFirOut);
        end
        @(negedge clk);
        rst = 1'b0;
        clearHist();
        strobe(1, 0, 21, NONE, NONE);
        strobe(0, 0, 21, NONE, NONE);
        strobe(0, 0, 21, NONE, NONE);
    endtask

    task automatic test_n_zero();
        strobe(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, 0, NONE, NONE);
        strobe(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, 0, NONE, NONE);
    endtask

    task automatic test_back_to_back();
        int nList [10] = '{0, 1, 5, 21, 31, 32, 40, 63, 7, 17};
        for (int a = 0; a < TAPS; a++) writeCoef(a, int'($urandom_range(0, 3000)) - 1500);
        for (int i = 0; i < 10; i++)
            strobe(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, nList[i], NONE, NONE);
    endtask

    initial begin
        bus.iEnSample        = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        bus.iCoeffWrEn       = 1'b0;
        bus.iAddrRam         = '0;
        bus.iWrDtRam         = '0;
        bus.iNumOfCoeff      = 6'd21;
        bus.iFirIn           = '0;
        test_reset();
        loadList();
        test_impulse(1, 0);
        test_impulse(0, -1);
        test_saturation();
        test_overrun();
        test_flag_strobe();
        test_write_while_busy();
        test_reset_mid_mac();
        test_n_zero();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
